mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter BURSTLEN, default 32, meaning data beats per memory burst (legal 1..65535).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning maximum idle cycles between beats before abort (0 disables).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports rq0_rdaddr / rq1_rdaddr  input  32  requester read address (rq0 = icache, rq1 = dcache).
REQ-006 The block SHALL have ports rq0_rdreq / rq1_rdreq  input  1  level request, held until grant.
REQ-007 The block SHALL have ports rq0_grant / rq1_grant  output  1  one-cycle pulse: request accepted.
REQ-008 The block SHALL have ports rq0_dataout / rq1_dataout  output  32  burst data to requester.
REQ-009 The block SHALL have ports rq0_datavalid / rq1_datavalid  output  1  data beat qualifier.
REQ-010 The block SHALL have ports rq0_error / rq1_error  output  1  one-cycle pulse: burst aborted by timeout.
REQ-011 The block SHALL have port mem_rdaddr  output  32  burst start address to memory.
REQ-012 The block SHALL have port mem_rdreq  output  1  one-cycle burst request pulse.
REQ-013 The block SHALL have port mem_burstlen  output  16  constant BURSTLEN.
REQ-014 The block SHALL have ports mem_dataout  input  32  and mem_datavalid  input  1  memory return data and qualifier.

Function
REQ-015 The FSM SHALL have states IDLE and BURST; reset enters IDLE.
REQ-016 In IDLE, on a rising edge with any rdreq high, the block SHALL go to BURST and, for the following cycle only, drive mem_rdreq=1 and the winner's grant=1.
REQ-017 On that same edge the block SHALL register the winner's rdaddr into mem_rdaddr unchanged and SHALL hold it until the next grant.
REQ-018 With exactly one request pending, that requester SHALL win.
REQ-019 With both requests pending, the requester not granted last SHALL win (round-robin); after reset rq0 SHALL win the first tie.
REQ-020 rq0_dataout and rq1_dataout SHALL both equal mem_dataout combinationally.
REQ-021 rqN_datavalid SHALL equal mem_datavalid AND (state==BURST) AND (owner==N); the non-owner datavalid SHALL stay 0.
REQ-022 In BURST a 16-bit beat counter SHALL count mem_datavalid cycles, including a beat in the mem_rdreq cycle.
REQ-023 On the edge that accepts beat number BURSTLEN the FSM SHALL return to IDLE and clear the counter.
REQ-024 Beats arriving in IDLE SHALL be dropped (no datavalid to either requester).
REQ-025 A new grant SHALL NOT occur earlier than the first edge in IDLE, giving a minimum of one IDLE cycle between bursts.
REQ-026 A requester SHALL keep rdreq high until its grant; a request dropped before grant SHALL be ignored without error.
REQ-027 A requester's rdreq held high through its grant cycle SHALL count as a new request at the next IDLE edge.
REQ-028 With TIMEOUT>0, a 16-bit idle counter SHALL reset on each beat and increment otherwise while in BURST.
REQ-029 When the idle counter reaches TIMEOUT, the block SHALL return to IDLE, pulse the owner's rqN_error for one cycle, and not forward further beats of that burst.
REQ-030 Grant, error and mem_rdreq SHALL never be asserted for both requesters or for more than one consecutive cycle.

Reset
REQ-031 Reset assertion SHALL immediately force state=IDLE, counters=0, mem_rdreq=0, mem_rdaddr=0, all grant/error=0, and the round-robin pointer to favour rq0.
REQ-032 During reset, rqN_datavalid SHALL be 0.
REQ-033 Reset asserted mid-burst SHALL abandon the burst; residual memory beats after release SHALL be dropped per REQ-024.

Verification
REQ-034 rq0 requests 0x00000000 alone -> rq0_grant and mem_rdreq pulse one cycle later with mem_rdaddr=0x00000000; 32 beats arrive on rq0_datavalid only; IDLE after the 32nd beat.
REQ-035 rq0 and rq1 request on the same edge after reset (0x00000000, 0x20000000) -> rq0 is served first; rq1 is granted after the 32nd beat plus one IDLE cycle, with mem_rdaddr=0x20000000.
REQ-036 Both requesters hold rdreq continuously for 4 bursts -> grants alternate rq0, rq1, rq0, rq1; mem_rdreq pulses are exactly 4.
REQ-037 Memory returns 33 beats for one burst -> the 33rd beat is not forwarded to either requester.
REQ-038 TIMEOUT=16 and memory stalls after beat 5 -> after 16 beat-less cycles owner error pulses once, the FSM is IDLE, and later beats are dropped.
REQ-039 Reset pulsed at beat 10 of an rq1 burst -> all outputs return to 0 immediately; the next tie after release grants rq0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving icache (rq0) / dcache (rq1) bursts on one memory read port.
// Grant and mem_rdreq pulse one cycle after the request edge; beats go combinationally to the owner; no backpressure to memory.
module mem_arbiter #(
    parameter int BURSTLEN = 32,
    parameter int TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rq0_rdaddr,
    input  logic        rq0_rdreq,
    output logic        rq0_grant,
    output logic [31:0] rq0_dataout,
    output logic        rq0_datavalid,
    output logic        rq0_error,
    input  logic [31:0] rq1_rdaddr,
    input  logic        rq1_rdreq,
    output logic        rq1_grant,
    output logic [31:0] rq1_dataout,
    output logic        rq1_datavalid,
    output logic        rq1_error,
    output logic [31:0] mem_rdaddr,
    output logic        mem_rdreq,
    output logic [15:0] mem_burstlen,
    input  logic [31:0] mem_dataout,
    input  logic        mem_datavalid
);
    localparam logic [15:0] BEATS_LAST = 16'(BURSTLEN - 1);
    localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT - 1);
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner;
    logic        last_win;
    logic        win;
    logic        any_req;
    logic        start;
    logic        beat_done;
    logic        timed_out;
    logic [15:0] beat_cnt;
    logic [15:0] idle_cnt;

    // last_win resets to rq1 so the first tie after reset goes to rq0
    always_comb begin
        any_req   = rq0_rdreq | rq1_rdreq;
        win       = (rq0_rdreq && rq1_rdreq) ? ~last_win : rq1_rdreq;
        start     = (state == IDLE) && any_req;
        beat_done = mem_datavalid && (beat_cnt == BEATS_LAST);
        timed_out = TIMEOUT_EN && !mem_datavalid && (idle_cnt == IDLE_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BURST;
            BURST:   if (beat_done || timed_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt   <= '0;
            idle_cnt   <= '0;
            owner      <= 1'b0;
            last_win   <= 1'b1;
            mem_rdaddr <= '0;
            mem_rdreq  <= 1'b0;
            rq0_grant  <= 1'b0;
            rq1_grant  <= 1'b0;
            rq0_error  <= 1'b0;
            rq1_error  <= 1'b0;
        end else begin
            mem_rdreq <= start;
            rq0_grant <= start && !win;
            rq1_grant <= start && win;
            rq0_error <= (state == BURST) && timed_out && !owner;
            rq1_error <= (state == BURST) && timed_out && owner;
            if (start) begin
                mem_rdaddr <= win ? rq1_rdaddr : rq0_rdaddr;
                owner      <= win;
                last_win   <= win;
            end
            // Counters live only while a burst continues; any exit clears them
            if ((state == BURST) && (state_nxt == BURST)) begin
                beat_cnt <= beat_cnt + {15'd0, mem_datavalid};
                idle_cnt <= mem_datavalid ? 16'd0 : idle_cnt + 16'd1;
            end else begin
                beat_cnt <= '0;
                idle_cnt <= '0;
            end
        end
    end

    always_comb begin
        rq0_dataout   = mem_dataout;
        rq1_dataout   = mem_dataout;
        rq0_datavalid = mem_datavalid && (state == BURST) && !owner;
        rq1_datavalid = mem_datavalid && (state == BURST) && owner;
        mem_burstlen  = 16'(BURSTLEN);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors and sequences, then random traffic against a burst-level model.
module tb_mem_arbiter;
    localparam int BL = 32;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rq0_rdaddr;
    logic        rq0_rdreq;
    logic        rq0_grant;
    logic [31:0] rq0_dataout;
    logic        rq0_datavalid;
    logic        rq0_error;
    logic [31:0] rq1_rdaddr;
    logic        rq1_rdreq;
    logic        rq1_grant;
    logic [31:0] rq1_dataout;
    logic        rq1_datavalid;
    logic        rq1_error;
    logic [31:0] mem_rdaddr;
    logic        mem_rdreq;
    logic [15:0] mem_burstlen;
    logic [31:0] mem_dataout;
    logic        mem_datavalid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        dv;
        logic [31:0] d;
        logic        g0;
        logic        g1;
        logic        mrq;
        logic        dv0;
        logic        dv1;
        logic [31:0] addr;
    } vec_t;

    mem_arbiter #(.BURSTLEN(BL), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .rq0_rdaddr    (rq0_rdaddr),
        .rq0_rdreq     (rq0_rdreq),
        .rq0_grant     (rq0_grant),
        .rq0_dataout   (rq0_dataout),
        .rq0_datavalid (rq0_datavalid),
        .rq0_error     (rq0_error),
        .rq1_rdaddr    (rq1_rdaddr),
        .rq1_rdreq     (rq1_rdreq),
        .rq1_grant     (rq1_grant),
        .rq1_dataout   (rq1_dataout),
        .rq1_datavalid (rq1_datavalid),
        .rq1_error     (rq1_error),
        .mem_rdaddr    (mem_rdaddr),
        .mem_rdreq     (mem_rdreq),
        .mem_burstlen  (mem_burstlen),
        .mem_dataout   (mem_dataout),
        .mem_datavalid (mem_datavalid)
    );

    always #5 clk = ~clk;

    // Burst-level reference: busy flag, owner, beats received, quiet cycles since last beat
    bit          m_busy;
    bit          m_owner;
    bit          m_prefer1;
    int          m_got;
    int          m_quiet;
    bit          e_g0, e_g1, e_mrq, e_err0, e_err1;
    logic [31:0] e_addr;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy    = 1'b0;
        m_owner   = 1'b0;
        m_prefer1 = 1'b0;
        m_got     = 0;
        m_quiet   = 0;
        e_g0      = 1'b0;
        e_g1      = 1'b0;
        e_mrq     = 1'b0;
        e_err0    = 1'b0;
        e_err1    = 1'b0;
        e_addr    = '0;
    endfunction

    function automatic void model_edge();
        bit w;
        e_g0   = 1'b0;
        e_g1   = 1'b0;
        e_mrq  = 1'b0;
        e_err0 = 1'b0;
        e_err1 = 1'b0;
        if (!m_busy) begin
            if (rq0_rdreq || rq1_rdreq) begin
                if (rq0_rdreq && rq1_rdreq) w = m_prefer1;
                else w = rq1_rdreq;
                m_busy    = 1'b1;
                m_owner   = w;
                m_got     = 0;
                m_quiet   = 0;
                m_prefer1 = !w;
                e_mrq     = 1'b1;
                if (w) begin
                    e_g1   = 1'b1;
                    e_addr = rq1_rdaddr;
                end else begin
                    e_g0   = 1'b1;
                    e_addr = rq0_rdaddr;
                end
            end
        end else if (mem_datavalid) begin
            m_got   = m_got + 1;
            m_quiet = 0;
            if (m_got == BL) m_busy = 1'b0;
        end else begin
            m_quiet = m_quiet + 1;
            if (TO > 0 && m_quiet == TO) begin
                m_busy = 1'b0;
                if (m_owner) e_err1 = 1'b1;
                else e_err0 = 1'b1;
            end
        end
    endfunction

    task automatic model_check();
        logic xdv0, xdv1;
        xdv0 = mem_datavalid && m_busy && !m_owner;
        xdv1 = mem_datavalid && m_busy && m_owner;
        chk1("m_grant0", rq0_grant, e_g0);
        chk1("m_grant1", rq1_grant, e_g1);
        chk1("m_mem_rdreq", mem_rdreq, e_mrq);
        chk32("m_mem_rdaddr", mem_rdaddr, e_addr);
        chk1("m_error0", rq0_error, e_err0);
        chk1("m_error1", rq1_error, e_err1);
        chk1("m_datavalid0", rq0_datavalid, xdv0);
        chk1("m_datavalid1", rq1_datavalid, xdv1);
        chk32("m_dataout0", rq0_dataout, mem_dataout);
        chk32("m_dataout1", rq1_dataout, mem_dataout);
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[5];
        int   order[$];
        int   pulses;
        int   stall;

        //          r0    r1    a0     a1             dv    d              g0    g1    mrq   dv0   dv1   addr
        tbl[0] = '{1'b1, 1'b1, 32'h0, 32'h2000_0000, 1'b1, 32'hdead_beef, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h0, 32'h2000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 32'h0, 32'h2000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b1, 32'h0, 32'h2000_0000, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 32'h0, 32'h2000_0000, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

        reset         = 1'b1;
        rq0_rdreq     = 1'b0;
        rq1_rdreq     = 1'b0;
        rq0_rdaddr    = '0;
        rq1_rdaddr    = '0;
        mem_dataout   = '0;
        mem_datavalid = 1'b0;
        model_reset();

        @(negedge clk);
        rq0_rdreq     = 1'b1;
        mem_datavalid = 1'b1;
        mem_dataout   = 32'h5a5a_0001;
        settle();
        chk1("rst_grant0", rq0_grant, 1'b0);
        chk1("rst_mem_rdreq", mem_rdreq, 1'b0);
        chk32("rst_mem_rdaddr", mem_rdaddr, 32'h0);
        chk1("rst_datavalid0", rq0_datavalid, 1'b0);
        chk32("mem_burstlen", 32'(mem_burstlen), 32'(BL));
        advance();
        rq0_rdreq     = 1'b0;
        mem_datavalid = 1'b0;
        reset         = 1'b0;

        // Tie right after reset: rq0 first, beat in the grant cycle forwarded
        for (int i = 0; i < 5; i++) begin
            rq0_rdreq     = tbl[i].r0;
            rq1_rdreq     = tbl[i].r1;
            rq0_rdaddr    = tbl[i].a0;
            rq1_rdaddr    = tbl[i].a1;
            mem_datavalid = tbl[i].dv;
            mem_dataout   = tbl[i].d;
            settle();
            chk1($sformatf("vec%0d_grant0", i), rq0_grant, tbl[i].g0);
            chk1($sformatf("vec%0d_grant1", i), rq1_grant, tbl[i].g1);
            chk1($sformatf("vec%0d_mem_rdreq", i), mem_rdreq, tbl[i].mrq);
            chk1($sformatf("vec%0d_datavalid0", i), rq0_datavalid, tbl[i].dv0);
            chk1($sformatf("vec%0d_datavalid1", i), rq1_datavalid, tbl[i].dv1);
            chk32($sformatf("vec%0d_mem_rdaddr", i), mem_rdaddr, tbl[i].addr);
            advance();
        end

        for (int b = 4; b <= BL; b++) begin
            mem_datavalid = 1'b1;
            mem_dataout   = 32'(b);
            settle();
            chk1("burst0_datavalid0", rq0_datavalid, 1'b1);
            chk1("burst0_datavalid1", rq1_datavalid, 1'b0);
            advance();
        end

        // 33rd beat lands in the mandatory IDLE cycle
        mem_dataout = 32'hbad0_0033;
        settle();
        chk1("beat33_datavalid0", rq0_datavalid, 1'b0);
        chk1("beat33_datavalid1", rq1_datavalid, 1'b0);
        chk1("idle_gap_grant1", rq1_grant, 1'b0);
        advance();
        mem_datavalid = 1'b0;
        settle();
        chk1("rq1_grant", rq1_grant, 1'b1);
        chk1("rq1_grant0_low", rq0_grant, 1'b0);
        chk1("rq1_mem_rdreq", mem_rdreq, 1'b1);
        chk32("rq1_mem_rdaddr", mem_rdaddr, 32'h2000_0000);
        advance();
        rq1_rdreq = 1'b0;

        for (int b = 1; b <= 9; b++) begin
            mem_datavalid = 1'b1;
            mem_dataout   = 32'h1000 + 32'(b);
            settle();
            chk1("burst1_datavalid1", rq1_datavalid, 1'b1);
            chk1("burst1_datavalid0", rq0_datavalid, 1'b0);
            advance();
        end

        // Reset hits on beat 10 of the rq1 burst
        mem_datavalid = 1'b1;
        reset         = 1'b1;
        model_reset();
        settle();
        chk1("midrst_grant0", rq0_grant, 1'b0);
        chk1("midrst_grant1", rq1_grant, 1'b0);
        chk1("midrst_mem_rdreq", mem_rdreq, 1'b0);
        chk32("midrst_mem_rdaddr", mem_rdaddr, 32'h0);
        chk1("midrst_error1", rq1_error, 1'b0);
        chk1("midrst_datavalid1", rq1_datavalid, 1'b0);
        chk1("midrst_datavalid0", rq0_datavalid, 1'b0);
        advance();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk1("residual_datavalid1", rq1_datavalid, 1'b0);
            chk1("residual_datavalid0", rq0_datavalid, 1'b0);
            advance();
        end

        rq0_rdreq  = 1'b1;
        rq1_rdreq  = 1'b1;
        rq0_rdaddr = 32'h0000_0100;
        rq1_rdaddr = 32'h0000_0200;
        settle();
        chk1("tie_wait_grant0", rq0_grant, 1'b0);
        advance();
        pulses = 0;
        for (int c = 0; c < 4 * (BL + 1); c++) begin
            settle();
            if (c == 0) chk1("post_reset_tie_grant0", rq0_grant, 1'b1);
            if (rq0_grant) order.push_back(0);
            if (rq1_grant) order.push_back(1);
            if (mem_rdreq) pulses++;
            advance();
        end
        chk32("rr_grant_count", 32'(order.size()), 32'd4);
        chk32("rr_mem_rdreq_pulses", 32'(pulses), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++)
            chk32($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));

        // Fifth burst goes to rq0; stall after beat 5 until timeout
        rq0_rdreq = 1'b0;
        rq1_rdreq = 1'b0;
        settle();
        chk1("to_grant0", rq0_grant, 1'b1);
        chk32("to_mem_rdaddr", mem_rdaddr, 32'h0000_0100);
        advance();
        for (int b = 2; b <= 5; b++) begin
            settle();
            advance();
        end
        mem_datavalid = 1'b0;
        for (int k = 0; k < TO; k++) begin
            settle();
            chk1("to_error0_early", rq0_error, 1'b0);
            advance();
        end
        mem_datavalid = 1'b1;
        settle();
        chk1("to_error0", rq0_error, 1'b1);
        chk1("to_error1", rq1_error, 1'b0);
        chk1("to_dropped_datavalid0", rq0_datavalid, 1'b0);
        advance();
        settle();
        chk1("to_error0_one_cycle", rq0_error, 1'b0);
        chk1("to_dropped_datavalid0_b", rq0_datavalid, 1'b0);
        advance();

        mem_datavalid = 1'b0;
        stall = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rq0_rdreq) begin
                if (e_g0) rq0_rdreq = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 63) == 0) rq0_rdreq = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                rq0_rdreq  = 1'b1;
                rq0_rdaddr = $urandom;
            end
            if (rq1_rdreq) begin
                if (e_g1) rq1_rdreq = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 63) == 0) rq1_rdreq = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                rq1_rdreq  = 1'b1;
                rq1_rdaddr = $urandom;
            end
            if (stall > 0) begin
                stall--;
                mem_datavalid = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                stall         = int'($urandom_range(8, 24));
                mem_datavalid = 1'b0;
            end else begin
                mem_datavalid = ($urandom_range(0, 3) != 0);
            end
            mem_dataout = $urandom;
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
